// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS RAM read engine: FSM states, LFSR
// polynomial/seed for optional address dithering, and default widths.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_PHASE_W = 32;
  localparam int DEF_RD_LAT  = 1;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dds_ram_reader_if.sv
// Read-only port B of the waveform RAM: the reader is master (enable/address),
// the RAM is slave (returns data RD_LAT cycles later).
interface dds_ram_reader_if #(
  parameter int ADDR_W = dds_pkg::DEF_ADDR_W,
  parameter int DATA_W = dds_pkg::DEF_DATA_W
);
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  modport master (output ram_en, ram_addr, input ram_dout);
  modport slave  (input ram_en, ram_addr, output ram_dout);
endinterface

// File: rtl/dds_lfsr.sv
// 16-bit maximal-length Galois LFSR used to dither the table address.
// Advances only while en is high; restarts from the package seed on reset.
module dds_lfsr
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/dds_ram_reader.sv
// Phase-accumulator read engine: streams one waveform-RAM sample per cycle.
// Optional build macro DDS_DITHER_EN adds LFSR dither to the table address.
module dds_ram_reader
  import dds_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PHASE_W-1:0]  fcw,
  input  logic                fcw_ld,
  input  logic [ADDR_W-1:0]   pof,
  dds_ram_reader_if.master    ram,
  output logic [DATA_W-1:0]   sample,
  output logic                sample_valid,
  output logic                wrap,
  output logic                busy
);

  localparam int FRAC_W = PHASE_W - ADDR_W;

  state_t               state, state_nxt;
  logic [PHASE_W-1:0]   acc, acc_nxt, fcw_act, fcw_pend, phase_d;
  logic [PHASE_W:0]     sum;
  logic [1:0]           drain_cnt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [RD_LAT:0]      vpipe;

`ifdef DDS_DITHER_EN
  logic [15:0] lfsr;

  dds_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .value (lfsr)
  );

  // Dither touches only the sub-address fraction; acc and wrap stay clean.
  assign phase_d = acc_nxt + {{ADDR_W{1'b0}}, FRAC_W'({{FRAC_W{1'b0}}, lfsr})};
`else
  assign phase_d = acc_nxt;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    sum       = {1'b0, acc} + {1'b0, fcw_act};
    wrap      = 1'b0;
    busy      = (state != IDLE);
    acc_nxt   = '0;
    unique case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        wrap    = sum[PHASE_W];
        acc_nxt = sum[PHASE_W-1:0];
        if (!en) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == 2'(RD_LAT)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    addr_nxt = ADDR_W'(phase_d >> FRAC_W) + pof;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      fcw_act      <= '0;
      fcw_pend     <= '0;
      drain_cnt    <= '0;
      ram.ram_en   <= 1'b0;
      ram.ram_addr <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (fcw_ld) fcw_pend <= fcw;
      // Frequency changes land only at a wrap while running, keeping phase continuous.
      if (state == IDLE || wrap) fcw_act <= fcw_ld ? fcw : fcw_pend;
      if (state == IDLE)     acc <= '0;
      else if (state == RUN) acc <= sum[PHASE_W-1:0];
      ram.ram_en <= (state_nxt == RUN);
      if (state_nxt == RUN) ram.ram_addr <= addr_nxt;
    end
  end

  // vpipe[k] is high k+1 cycles after a read; RAM data is ready at RD_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe  <= '0;
      sample <= '0;
    end else begin
      vpipe <= {vpipe[RD_LAT-1:0], ram.ram_en};
      if (vpipe[RD_LAT-1]) sample <= ram.ram_dout;
    end
  end

  assign sample_valid = vpipe[RD_LAT];

endmodule
